sr_flag_sched: RTL

Command scheduler and arbiter for a bank of gated SR flag latches. NREQ requesters post set/reset commands against individual flags. The block grants them round-robin and drives the shared latch bank's s/r/en lines with fixed-width pulses. It never drives s=r=1 on any flag, and it keeps a shadow copy of the bank state. It sits between software/control agents and the latch bank, and is the only driver of the bank.

---
 rtl/sr_flag_sched_pkg.sv | 20 ++
 rtl/sr_flag_sched_if.sv | 18 +
 rtl/sr_flag_sched_rr_arbiter.sv | 39 +++
 rtl/sr_flag_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_sched_pkg.sv
// sr_flag_pkg: shared types and helpers for the SR flag scheduler.
//   state_e : scheduler FSM states
//   CNT_W   : width of the PULSE/GAP cycle counter
//   iw_of() : index width needed to address n items (minimum 1 bit)
package sr_flag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int CNT_W = 8;

  function automatic int iw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_flag_sched_if.sv
// sr_flag_sched_if: requester command handshake bundle.
//   req_valid [NREQ]     command pending per requester
//   req_set   [NREQ]     1 = set flag, 0 = reset flag
//   req_idx   [NREQ*IW]  flag index, requester k at [k*IW +: IW]
//   req_ready [NREQ]     one-hot accept from the scheduler
// master = requester side, slave = scheduler side.
interface sr_flag_sched_if #(
  parameter int NREQ = 4,
  parameter int IW   = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_set;
  logic [NREQ*IW-1:0] req_idx;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, output req_set, output req_idx, input req_ready);
  modport slave  (input req_valid, input req_set, input req_idx, output req_ready);
endinterface

// File: rtl/sr_flag_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   valid     [NREQ] candidate requests
//   ptr       [PW]   highest-priority requester this round
//   grant     [NREQ] one-hot winner (zero when nothing valid)
//   grant_idx [PW]   binary index of the winner
//   any              at least one request was valid
module rr_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = iw_of(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            any
);

  logic [PW-1:0] k_s;
  logic          hit_s;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k_s       = '0;
    hit_s     = 1'b0;
    for (int o = 0; o < NREQ; o++) begin
      k_s       = PW'((int'(ptr) + o) % NREQ);
      hit_s     = valid[k_s] & ~any;
      grant     = grant | (NREQ'(hit_s) << k_s);
      grant_idx = hit_s ? k_s : grant_idx;
      any       = any | hit_s;
    end
  end

endmodule

// File: rtl/sr_flag_sched.sv
// sr_flag_sched: round-robin command scheduler that is the sole driver of
// a bank of gated SR flag latches, with a shadow copy of the bank state.
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req        command handshake (slave side of sr_flag_sched_if)
//   clear_all  one-cycle request to clear the whole bank
//   lat_s/r    per-flag set/reset lines (never both high on one flag)
//   lat_en     shared enable; low forces every latch to 0
//   flags      shadow of the bank outputs
//   busy       FSM not in IDLE
//   err        one-cycle pulse after an out-of-range command is accepted
module sr_flag_sched
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int PULSE = 2,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  sr_flag_sched_if.slave   req,
  input  logic             clear_all,
  output logic [NFLAG-1:0] lat_s,
  output logic [NFLAG-1:0] lat_r,
  output logic             lat_en,
  output logic [NFLAG-1:0] flags,
  output logic             busy,
  output logic             err
);

  localparam int IW = iw_of(NFLAG);
  localparam int PW = iw_of(NREQ);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    rr_ptr_r;
  logic             clear_pend_r;
  logic [IW-1:0]    cmd_idx_r;
  logic             cmd_set_r;
  logic [NFLAG-1:0] flags_r;
  logic [NFLAG-1:0] lat_s_r;
  logic [NFLAG-1:0] lat_r_r;
  logic             lat_en_r;
  logic             busy_r;
  logic             err_r;

  logic             clear_req_s;
  logic             arb_en_s;
  logic [NREQ-1:0]  arb_valid_s;
  logic [NREQ-1:0]  grant_s;
  logic [PW-1:0]    gidx_s;
  logic             any_s;
  logic [IW-1:0]    sel_idx_s;
  logic             sel_set_s;
  logic             oor_s;
  logic             redundant_s;
  logic [NFLAG-1:0] cmd_oh_s;

  // A clear arriving this cycle already counts as pending, so it beats
  // any command and reaches the bank on the very next cycle.
  assign clear_req_s = clear_pend_r | clear_all;
  assign arb_en_s    = ~rst & (state_r == ST_IDLE) & ~clear_req_s;
  assign arb_valid_s = req.req_valid & {NREQ{arb_en_s}};

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .valid     (arb_valid_s),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (gidx_s),
    .any       (any_s)
  );

  assign req.req_ready = grant_s;

  // Decode the granted command against the shadow state.
  always_comb begin
    sel_idx_s   = req.req_idx[gidx_s*IW +: IW];
    sel_set_s   = req.req_set[gidx_s];
    oor_s       = ({1'b0, sel_idx_s} >= (IW+1)'(NFLAG));
    redundant_s = oor_s ? 1'b0 : (flags_r[sel_idx_s] == sel_set_s);
    cmd_oh_s    = NFLAG'(1'b1) << sel_idx_s;
  end

  // Scheduler FSM with all bank-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      rr_ptr_r     <= '0;
      clear_pend_r <= 1'b0;
      cmd_idx_r    <= '0;
      cmd_set_r    <= 1'b0;
      flags_r      <= '0;
      lat_s_r      <= '0;
      lat_r_r      <= '0;
      lat_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r        <= 1'b0;
      clear_pend_r <= clear_pend_r | clear_all;
      case (state_r)
        ST_IDLE: begin
          lat_en_r <= 1'b1;
          if (clear_req_s) begin
            state_r      <= ST_CLEAR;
            clear_pend_r <= 1'b0;
            lat_en_r     <= 1'b0;
            busy_r       <= 1'b1;
          end else if (any_s) begin
            rr_ptr_r <= (gidx_s == PW'(NREQ - 1)) ? '0 : gidx_s + PW'(1);
            if (oor_s) begin
              err_r <= 1'b1;
            end else if (redundant_s) begin
              busy_r <= 1'b0;
            end else begin
              state_r   <= ST_PULSE;
              cnt_r     <= '0;
              cmd_idx_r <= sel_idx_s;
              cmd_set_r <= sel_set_s;
              lat_s_r   <= sel_set_s ? cmd_oh_s : '0;
              lat_r_r   <= sel_set_s ? '0 : cmd_oh_s;
              busy_r    <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (cnt_r == PULSE_LAST) begin
            lat_s_r            <= '0;
            lat_r_r            <= '0;
            flags_r[cmd_idx_r] <= cmd_set_r;
            cnt_r              <= '0;
            if (GAP == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_GAP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          lat_en_r <= 1'b1;
          flags_r  <= '0;
          cnt_r    <= '0;
          if (GAP == 0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          lat_s_r  <= '0;
          lat_r_r  <= '0;
          lat_en_r <= 1'b1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign lat_s  = lat_s_r;
  assign lat_r  = lat_r_r;
  assign lat_en = lat_en_r;
  assign flags  = flags_r;
  assign busy   = busy_r;
  assign err    = err_r;

endmodule
